// File: rtl/ibsm.sv
// Input-buffer state machine: requests a crossbar output for the head packet of
// one input FIFO and pops it flit by flit once the arbiter grants.
module ibsm #(
  parameter int PKTW = 9,
  parameter int PORT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ack,
  input  logic [PKTW:0]   pkto,
  input  logic [PORT:0]   reqi,
  input  logic            empty,
  output logic            re,
  output logic [PORT:0]   req
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    SEND = 2'b10
  } state_t;

  localparam logic [1:0] TYPE_HEAD = 2'b10;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [PORT:0] req_next;
  logic        re_raw;
  logic [1:0]  flit_type;

  assign flit_type = pkto[PKTW:PKTW-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req   <= '0;
    end else begin
      state <= state_next;
      req   <= req_next;
    end
  end

  // Only a tail ends SEND; a header seen mid-packet is forwarded like any flit.
  always_comb begin
    state_next = state;
    req_next   = req;
    re_raw     = 1'b0;
    case (state)
      IDLE: begin
        req_next = '0;
        if (!empty) begin
          if (flit_type == TYPE_HEAD) begin
            req_next   = reqi;
            state_next = REQ;
          end else if (flit_type == TYPE_BODY || flit_type == TYPE_TAIL) begin
            re_raw = 1'b1;
          end
        end
      end
      REQ: begin
        if (ack) state_next = SEND;
      end
      SEND: begin
        re_raw = ack & ~empty;
        if (re_raw && flit_type == TYPE_TAIL) begin
          state_next = IDLE;
          req_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = '0;
      end
    endcase
  end

  // The pop strobe must stay low for the whole time reset is held.
  assign re = re_raw & rst;

endmodule

// File: tb/tb_ibsm.sv
// Directed self-checking bench for ibsm: reset, request, send, stall, stray
// flit drop and asynchronous reset mid-packet.
module tb_ibsm;

  logic       clk;
  logic       rst;
  logic       ack;
  logic [9:0] pkto;
  logic [3:0] reqi;
  logic       empty;
  logic       re;
  logic [3:0] req;

  int checks   = 0;
  int failures = 0;

  ibsm #(.PKTW(9), .PORT(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .ack   (ack),
    .pkto  (pkto),
    .reqi  (reqi),
    .empty (empty),
    .re    (re),
    .req   (req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b0; ack = 1'b0; empty = 1'b0; pkto = 10'b01_00000101; reqi = 4'b0000;
    #12;
    checks++;
    if (re !== 1'b0) begin failures++; $display("FAIL reset_re: got %b expected 0", re); end
    checks++;
    if (req !== 4'b0000) begin failures++; $display("FAIL reset_req: got %b expected 0000", req); end
    empty = 1'b1;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (req !== 4'b0000 || re !== 1'b0) begin
        failures++; $display("FAIL reset_idle: got req=%b re=%b expected req=0000 re=0", req, re);
      end
    end
  endtask

  task automatic test_header_wait();
    @(negedge clk); pkto = 10'b10_00000011; reqi = 4'b1000; empty = 1'b0; ack = 1'b0; #1;
    checks++;
    if (re !== 1'b0 || req !== 4'b0000) begin
      failures++; $display("FAIL hdr_seen: got req=%b re=%b expected req=0000 re=0", req, re);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); reqi = 4'b0001; #1;
      checks++;
      if (re !== 1'b0 || req !== 4'b1000) begin
        failures++; $display("FAIL hdr_wait: got req=%b re=%b expected req=1000 re=0", req, re);
      end
    end
  endtask

  task automatic test_send();
    logic [9:0] flits [0:5];
    int idx = 0;
    flits = '{10'b10_00000011, 10'b01_00000000, 10'b01_00000001,
              10'b01_00000010, 10'b01_00000011, 10'b11_00000000};
    @(negedge clk); ack = 1'b1; pkto = flits[0]; empty = 1'b0; #1;
    checks++;
    if (re !== 1'b0) begin failures++; $display("FAIL ack_latency: got re=%b expected 0", re); end
    for (int cyc = 0; cyc < 12 && idx < 6; cyc++) begin
      @(negedge clk); pkto = flits[idx]; empty = 1'b0; #1;
      checks++;
      if (re !== 1'b1 || req !== 4'b1000) begin
        failures++; $display("FAIL send_flit%0d: got re=%b req=%b expected re=1 req=1000", idx, re, req);
      end
      if (re === 1'b1) idx++;
    end
    checks++;
    if (idx !== 6) begin failures++; $display("FAIL send_pulses: got %0d expected 6", idx); end
    @(negedge clk); empty = 1'b1; #1;
    checks++;
    if (req !== 4'b0000 || re !== 1'b0) begin
      failures++; $display("FAIL send_release: got req=%b re=%b expected req=0000 re=0", req, re);
    end
    ack = 1'b0;
  endtask

  task automatic test_stall();
    @(negedge clk); pkto = 10'b10_00000111; reqi = 4'b0010; empty = 1'b0; ack = 1'b0;
    @(negedge clk); ack = 1'b1; #1;
    checks++;
    if (req !== 4'b0010 || re !== 1'b0) begin
      failures++; $display("FAIL stall_req: got req=%b re=%b expected req=0010 re=0", req, re);
    end
    @(negedge clk); #1;
    checks++;
    if (re !== 1'b1) begin failures++; $display("FAIL stall_hdr_pop: got re=%b expected 1", re); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); empty = 1'b1; pkto = 10'b00_00000000; #1;
      checks++;
      if (re !== 1'b0 || req !== 4'b0010) begin
        failures++; $display("FAIL stall_hold: got req=%b re=%b expected req=0010 re=0", req, re);
      end
    end
    @(negedge clk); empty = 1'b0; pkto = 10'b01_00001111; #1;
    checks++;
    if (re !== 1'b1 || req !== 4'b0010) begin
      failures++; $display("FAIL stall_resume: got req=%b re=%b expected req=0010 re=1", req, re);
    end
    @(negedge clk); pkto = 10'b11_00000001; #1;
    checks++;
    if (re !== 1'b1) begin failures++; $display("FAIL stall_tail: got re=%b expected 1", re); end
    @(negedge clk); empty = 1'b1; ack = 1'b0; #1;
    checks++;
    if (req !== 4'b0000) begin failures++; $display("FAIL stall_release: got req=%b expected 0000", req); end
  endtask

  task automatic test_stray();
    @(negedge clk); pkto = 10'b01_00000101; reqi = 4'b0100; empty = 1'b0; ack = 1'b0; #1;
    checks++;
    if (re !== 1'b1 || req !== 4'b0000) begin
      failures++; $display("FAIL stray_drop: got req=%b re=%b expected req=0000 re=1", req, re);
    end
    @(negedge clk); empty = 1'b1; #1;
    checks++;
    if (re !== 1'b0 || req !== 4'b0000) begin
      failures++; $display("FAIL stray_after: got req=%b re=%b expected req=0000 re=0", req, re);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); pkto = 10'b10_00000001; reqi = 4'b0100; empty = 1'b0; ack = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (req !== 4'b0100) begin failures++; $display("FAIL mid_req: got req=%b expected 0100", req); end
    @(negedge clk); pkto = 10'b01_00000010; #1;
    checks++;
    if (re !== 1'b1) begin failures++; $display("FAIL mid_send: got re=%b expected 1", re); end
    #1; rst = 1'b0; #1;
    checks++;
    if (req !== 4'b0000 || re !== 1'b0) begin
      failures++; $display("FAIL mid_async: got req=%b re=%b expected req=0000 re=0", req, re);
    end
    @(negedge clk); rst = 1'b1; pkto = 10'b10_00000100; reqi = 4'b0001; #1;
    checks++;
    if (re !== 1'b0) begin failures++; $display("FAIL mid_idle_hdr: got re=%b expected 0", re); end
    @(negedge clk); #1;
    checks++;
    if (req !== 4'b0001 || re !== 1'b0) begin
      failures++; $display("FAIL mid_rereq: got req=%b re=%b expected req=0001 re=0", req, re);
    end
  endtask

  initial begin
    test_reset();
    test_header_wait();
    test_send();
    test_stall();
    test_stray();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
